// File: rtl/door_access_if.sv
// Status/output bundle between the door_lock stage and door_access_ctrl.
// master drives the door_lock status lines, slave is the access controller.
interface door_access_if;
   logic       locked;
   logic       unlocked;
   logic       error;
   logic       relay_on;
   logic       alarm;
   logic       lockout;
   logic [3:0] fail_count;
   logic [1:0] state_o;

   modport master (
      output locked, unlocked, error,
      input  relay_on, alarm, lockout, fail_count, state_o
   );

   modport slave (
      input  locked, unlocked, error,
      output relay_on, alarm, lockout, fail_count, state_o
   );
endinterface

// File: rtl/door_access_ctrl.sv
// Door strike relay hold, consecutive-failure counting and timed lockout.
// Define ALARM_BLINK_EN to make the alarm blink every BLINK_HALF cycles during lockout.
//
// state   | meaning
// IDLE    | waiting for an unlock or error edge
// OPEN    | relay energised, hold timer running
// LOCKOUT | alarm on, key entry inhibited, lockout timer running
module door_access_ctrl #(
   parameter int MAX_FAILS      = 3,
   parameter int RELAY_CYCLES   = 200,
   parameter int LOCKOUT_CYCLES = 1000,
   parameter int CNT_W          = 16
`ifdef ALARM_BLINK_EN
   ,
   parameter int BLINK_HALF     = 8
`endif
) (
   input  logic          clk,
   input  logic          rst,
   door_access_if.slave  bus
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_OPEN    = 2'd1,
      S_LOCKOUT = 2'd2
   } state_t;

   localparam logic [3:0]       FAIL_MAX   = 4'(MAX_FAILS);
   localparam logic [CNT_W-1:0] RELAY_LOAD = CNT_W'(RELAY_CYCLES - 1);
   localparam logic [CNT_W-1:0] LOCK_LOAD  = CNT_W'(LOCKOUT_CYCLES - 1);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] timer, timer_nxt;
   logic [3:0]       fail_cnt, fail_nxt;
   logic             locked_prev, unlocked_prev, error_prev;
   logic             relay_q, lockout_q, alarm_q;
   logic             locked_rise, unlocked_rise, error_rise;
   logic             open_exit;

   assign locked_rise   = bus.locked   & ~locked_prev;
   assign unlocked_rise = bus.unlocked & ~unlocked_prev;
   assign error_rise    = bus.error    & ~error_prev;

   always_comb begin
      state_nxt = state;
      timer_nxt = timer;
      fail_nxt  = fail_cnt;
      open_exit = 1'b0;
      case (state)
         S_IDLE: begin
            if (fail_cnt >= FAIL_MAX) begin
               // count saturated while OPEN: lock out as soon as the relay drops
               state_nxt = S_LOCKOUT;
               timer_nxt = LOCK_LOAD;
            end else if (error_rise) begin
               fail_nxt = fail_cnt + 4'd1;
               if (fail_nxt == FAIL_MAX) begin
                  state_nxt = S_LOCKOUT;
                  timer_nxt = LOCK_LOAD;
               end
            end else if (unlocked_rise) begin
               fail_nxt  = 4'd0;
               state_nxt = S_OPEN;
               timer_nxt = RELAY_LOAD;
            end
         end
         S_OPEN: begin
            if (locked_rise) begin
               open_exit = 1'b1;
            end else if (unlocked_rise) begin
               timer_nxt = RELAY_LOAD;
            end else begin
               if (error_rise && (fail_cnt < FAIL_MAX))
                  fail_nxt = fail_cnt + 4'd1;
               if (timer == '0)
                  open_exit = 1'b1;
               else
                  timer_nxt = timer - 1'b1;
            end
            if (open_exit) begin
               if (fail_nxt == FAIL_MAX) begin
                  state_nxt = S_LOCKOUT;
                  timer_nxt = LOCK_LOAD;
               end else begin
                  state_nxt = S_IDLE;
                  timer_nxt = '0;
               end
            end
         end
         S_LOCKOUT: begin
            if (timer == '0) begin
               state_nxt = S_IDLE;
               fail_nxt  = 4'd0;
            end else begin
               timer_nxt = timer - 1'b1;
            end
         end
         default: begin
            state_nxt = S_IDLE;
            timer_nxt = '0;
            fail_nxt  = 4'd0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state         <= S_IDLE;
         timer         <= '0;
         fail_cnt      <= 4'd0;
         locked_prev   <= 1'b1;
         unlocked_prev <= 1'b1;
         error_prev    <= 1'b1;
         relay_q       <= 1'b0;
         lockout_q     <= 1'b0;
      end else begin
         state         <= state_nxt;
         timer         <= timer_nxt;
         fail_cnt      <= fail_nxt;
         locked_prev   <= bus.locked;
         unlocked_prev <= bus.unlocked;
         error_prev    <= bus.error;
         relay_q       <= (state_nxt == S_OPEN);
         lockout_q     <= (state_nxt == S_LOCKOUT);
      end
   end

`ifdef ALARM_BLINK_EN
   localparam logic [15:0] BLINK_LOAD = 16'(BLINK_HALF - 1);
   logic [15:0] blink_cnt;

   always_ff @(posedge clk) begin
      if (!rst) begin
         alarm_q   <= 1'b0;
         blink_cnt <= '0;
      end else if (state_nxt == S_LOCKOUT) begin
         if (state != S_LOCKOUT) begin
            alarm_q   <= 1'b1;
            blink_cnt <= BLINK_LOAD;
         end else if (blink_cnt == '0) begin
            alarm_q   <= ~alarm_q;
            blink_cnt <= BLINK_LOAD;
         end else begin
            blink_cnt <= blink_cnt - 1'b1;
         end
      end else begin
         alarm_q   <= 1'b0;
         blink_cnt <= '0;
      end
   end
`else
   always_ff @(posedge clk) begin
      if (!rst)
         alarm_q <= 1'b0;
      else
         alarm_q <= (state_nxt == S_LOCKOUT);
   end
`endif

   assign bus.relay_on   = relay_q;
   assign bus.alarm      = alarm_q;
   assign bus.lockout    = lockout_q;
   assign bus.fail_count = fail_cnt;
   assign bus.state_o    = state;

endmodule

// File: tb/tb_door_access_ctrl.sv
// Directed scoreboard bench for door_access_ctrl (MAX_FAILS=3, RELAY_CYCLES=4, LOCKOUT_CYCLES=10).
// The driver queues the hand-derived output vector for each clock; the monitor checks it 1 ns after the edge.
module tb_door_access_ctrl;

   localparam int BH = 2;

   typedef struct packed {
      logic       relay;
      logic       alarm;
      logic       lockout;
      logic [3:0] fc;
      logic [1:0] st;
   } exp_t;

   logic clk;
   logic rst;
   door_access_if bus ();

   exp_t  q[$];
   string tq[$];
   int    checks = 0;
   int    errors = 0;
   string tag = "";

   door_access_ctrl #(
      .MAX_FAILS(3),
      .RELAY_CYCLES(4),
      .LOCKOUT_CYCLES(10),
      .CNT_W(16)
`ifdef ALARM_BLINK_EN
      ,
      .BLINK_HALF(BH)
`endif
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic exp_t ex(input logic r, input logic a, input logic l,
                               input logic [3:0] f, input logic [1:0] s);
      exp_t x;
      x.relay = r; x.alarm = a; x.lockout = l; x.fc = f; x.st = s;
      return x;
   endfunction

   function automatic exp_t idle(input logic [3:0] f);
      return ex(1'b0, 1'b0, 1'b0, f, 2'd0);
   endfunction

   function automatic exp_t opn(input logic [3:0] f);
      return ex(1'b1, 1'b0, 1'b0, f, 2'd1);
   endfunction

   // k = 0 is the first lockout cycle
   function automatic exp_t lck(input int k);
      logic a;
`ifdef ALARM_BLINK_EN
      a = ((k / BH) % 2) == 0;
`else
      a = 1'b1;
`endif
      return ex(1'b0, a, 1'b1, 4'd3, 2'd2);
   endfunction

   task automatic cyc(input logic r, input logic l, input logic u, input logic e, input exp_t x);
      @(negedge clk);
      rst          = r;
      bus.locked   = l;
      bus.unlocked = u;
      bus.error    = e;
      q.push_back(x);
      tq.push_back(tag);
   endtask

   initial begin
      exp_t  x, a;
      string t;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            x = q.pop_front();
            t = tq.pop_front();
            a = {bus.relay_on, bus.alarm, bus.lockout, bus.fail_count, bus.state_o};
            checks++;
            if (a !== x) begin
               errors++;
               $display("FAIL %s @%0t: got relay=%b alarm=%b lockout=%b fc=%0d st=%0d, expected relay=%b alarm=%b lockout=%b fc=%0d st=%0d",
                        t, $time, a.relay, a.alarm, a.lockout, a.fc, a.st,
                        x.relay, x.alarm, x.lockout, x.fc, x.st);
            end
         end
      end
   end

   initial begin
      rst = 1'b0;
      bus.locked = 1'b0;
      bus.unlocked = 1'b1;
      bus.error = 1'b1;

      tag = "reset";
      cyc(0, 0, 1, 1, idle(0));
      cyc(0, 0, 1, 1, idle(0));
      tag = "release_no_edge";
      cyc(1, 0, 1, 1, idle(0));
      cyc(1, 0, 0, 0, idle(0));

      tag = "unlock_hold";
      cyc(1, 0, 1, 0, opn(0));
      repeat (3) cyc(1, 0, 0, 0, opn(0));
      tag = "unlock_release";
      cyc(1, 0, 0, 0, idle(0));

      tag = "fail_count";
      cyc(1, 0, 0, 1, idle(1));
      cyc(1, 0, 0, 0, idle(1));
      cyc(1, 0, 0, 1, idle(2));
      cyc(1, 0, 0, 0, idle(2));
      tag = "lockout";
      cyc(1, 0, 0, 1, lck(0));
      for (int k = 1; k < 10; k++) cyc(1, 0, (k == 3), 0, lck(k));
      tag = "lockout_exit";
      cyc(1, 0, 0, 0, idle(0));
      cyc(1, 0, 0, 0, idle(0));

      tag = "retrigger";
      cyc(1, 0, 1, 0, opn(0));
      cyc(1, 0, 0, 0, opn(0));
      cyc(1, 0, 1, 0, opn(0));
      repeat (3) cyc(1, 0, 0, 0, opn(0));
      tag = "retrigger_release";
      cyc(1, 0, 0, 0, idle(0));

      tag = "locked_abort";
      cyc(1, 0, 1, 0, opn(0));
      cyc(1, 1, 0, 0, idle(0));
      cyc(1, 0, 0, 0, idle(0));

      tag = "error_in_open";
      cyc(1, 0, 1, 0, opn(0));
      cyc(1, 0, 0, 1, opn(1));
      cyc(1, 0, 0, 0, opn(1));
      cyc(1, 0, 0, 0, opn(1));
      cyc(1, 0, 0, 0, idle(1));

      tag = "simultaneous";
      cyc(1, 0, 0, 1, idle(2));
      cyc(1, 0, 0, 0, idle(2));
      cyc(1, 0, 1, 1, lck(0));
      for (int k = 1; k < 5; k++) cyc(1, 0, 0, 0, lck(k));
      tag = "reset_mid_lockout";
      cyc(0, 0, 0, 0, idle(0));
      cyc(1, 0, 0, 0, idle(0));
      cyc(1, 0, 0, 0, idle(0));

      for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
      #2;
      if (q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain: %0d expected vectors left unchecked, required 0", q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
